// File: rtl/burst_fill_seq.sv
// Cache line-fill sequencer: issues four word reads per 8-byte line and
// forwards the fixed-latency returns to the cache data array in order.
module burst_fill_seq #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        mem_stall,
    input  logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        fill_we,
    output logic [1:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [12:0]               line_q, line_d;
    logic [1:0]                issue_cnt_q, issue_cnt_d;
    logic [1:0]                ret_cnt_q, ret_cnt_d;
    logic [LATENCY-1:0]        vld_q, vld_d;
    logic [LATENCY-1:0][1:0]   off_q, off_d;
    logic                      push;

    assign fill_we   = vld_q[LATENCY-1];
    assign fill_word = off_q[LATENCY-1];
    assign fill_data = mem_data_in;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_addr  = mem_rd ? {line_q, issue_cnt_q, 1'b0} : 16'h0000;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        mem_rd      = 1'b0;
        push        = 1'b0;
        err         = start && (state_q != IDLE);

        if (fill_we) begin
            ret_cnt_d = ret_cnt_q + 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    line_d      = base_addr[15:3];
                    issue_cnt_d = 2'd0;
                    ret_cnt_d   = 2'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd = !mem_stall;
                if (!mem_stall) begin
                    push        = 1'b1;
                    issue_cnt_d = issue_cnt_q + 2'd1;
                    if (issue_cnt_q == 2'd3) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fill_we && ret_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Return pipeline shifts every cycle; stalled issue slots carry valid=0.
    always_comb begin
        vld_d    = vld_q;
        off_d    = off_q;
        vld_d[0] = push;
        off_d[0] = push ? issue_cnt_q : 2'd0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            off_d[i] = off_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vld_q       <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            vld_q       <= vld_d;
            off_q       <= off_d;
        end
    end

endmodule

// File: tb/tb_burst_fill_seq.sv
// Directed bench for burst_fill_seq: LATENCY 1, 2 and 4 instances share
// stimulus; per-cycle output masks are compared to hand-derived constants.
module tb_burst_fill_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_stall;
    logic [15:0] mem_data_in;

    logic        rd1, we1, busy1, done1, err1;
    logic        rd2, we2, busy2, done2, err2;
    logic        rd4, we4, busy4, done4, err4;
    logic [15:0] addr1, addr2, addr4, fd1, fd2, fd4;
    logic [1:0]  word1, word2, word4;

    burst_fill_seq #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .mem_stall(mem_stall), .mem_data_in(mem_data_in),
        .mem_rd(rd1), .mem_addr(addr1), .fill_we(we1), .fill_word(word1),
        .fill_data(fd1), .busy(busy1), .done(done1), .err(err1)
    );
    burst_fill_seq #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .mem_stall(mem_stall), .mem_data_in(mem_data_in),
        .mem_rd(rd2), .mem_addr(addr2), .fill_we(we2), .fill_word(word2),
        .fill_data(fd2), .busy(busy2), .done(done2), .err(err2)
    );
    burst_fill_seq #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .mem_stall(mem_stall), .mem_data_in(mem_data_in),
        .mem_rd(rd4), .mem_addr(addr4), .fill_we(we4), .fill_word(word4),
        .fill_data(fd4), .busy(busy4), .done(done4), .err(err4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] rd_m, we1_m, we2_m, we4_m, dn1_m, dn2_m, dn4_m;
    logic [31:0] bz1_m, bz2_m, bz4_m, er1_m, er2_m, er4_m;
    logic [15:0] addr_q[$];
    logic [7:0]  word_seq;
    int          z_bad, pt_bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec2();
        return {9'd0, rd2, addr2, we2, word2, busy2, done2, err2};
    endfunction

    task automatic chk_addrs(input string tag, input logic [15:0] first);
        chk({tag, "_n"}, addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_q.size()) begin
                chk(tag, addr_q[i], first + 16'(2 * i));
            end
        end
    endtask

    // Cycle 0 carries start; cycles 1..ncyc are recorded into bit masks.
    task automatic scen(input logic [15:0] base, input logic [31:0] stall,
                        input int rs_cyc, input logic [15:0] rs_addr,
                        input int rst_cyc, input int ncyc);
        rd_m = 0; we1_m = 0; we2_m = 0; we4_m = 0;
        dn1_m = 0; dn2_m = 0; dn4_m = 0;
        bz1_m = 0; bz2_m = 0; bz4_m = 0;
        er1_m = 0; er2_m = 0; er4_m = 0;
        addr_q.delete();
        word_seq = 0; z_bad = 0; pt_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; mem_stall = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start       = (c == rs_cyc);
            base_addr   = (c == rs_cyc) ? rs_addr : base;
            mem_stall   = stall[c];
            rst         = (c == rst_cyc);
            mem_data_in = 16'hA500 ^ c[15:0];
            if (c == rst_cyc) begin
                #1;
                chk("rst_async", out_vec2(), 0);
            end
            @(negedge clk);
            rd_m[c] = rd2;
            we1_m[c] = we1; we2_m[c] = we2; we4_m[c] = we4;
            dn1_m[c] = done1; dn2_m[c] = done2; dn4_m[c] = done4;
            bz1_m[c] = busy1; bz2_m[c] = busy2; bz4_m[c] = busy4;
            er1_m[c] = err1; er2_m[c] = err2; er4_m[c] = err4;
            if (rd2) addr_q.push_back(addr2);
            else if (addr2 != 16'h0) z_bad++;
            if (we2) word_seq = {word_seq[5:0], word2};
            if (fd2 != mem_data_in) pt_bad++;
        end
        start = 1'b0; mem_stall = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 16'h0;
        mem_stall = 1'b0; mem_data_in = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_vals", out_vec2(), 0);
        rst = 1'b0;

        scen(16'h1235, 32'h0, 0, 16'h0, 0, 12);
        chk("basic_rd", rd_m, 32'h1E);
        chk_addrs("basic_addr", 16'h1230);
        chk("basic_we2", we2_m, 32'h78);
        chk("basic_words", word_seq, 8'h1B);
        chk("basic_done2", dn2_m, 32'h80);
        chk("basic_busy2", bz2_m, 32'hFE);
        chk("basic_err2", er2_m, 32'h0);
        chk("basic_we1", we1_m, 32'h3C);
        chk("basic_done1", dn1_m, 32'h40);
        chk("basic_we4", we4_m, 32'h1E0);
        chk("basic_done4", dn4_m, 32'h200);
        chk("addr_zero", z_bad, 0);
        chk("fill_data", pt_bad, 0);

        scen(16'h1235, 32'hC, 0, 16'h0, 0, 14);
        chk("stall_rd", rd_m, 32'h72);
        chk_addrs("stall_addr", 16'h1230);
        chk("stall_we2", we2_m, 32'h1C8);
        chk("stall_words", word_seq, 8'h1B);
        chk("stall_done2", dn2_m, 32'h200);
        chk("stall_busy2", bz2_m, 32'h3FE);
        chk("stall_we1", we1_m, 32'hE4);
        chk("stall_done1", dn1_m, 32'h100);
        chk("stall_we4", we4_m, 32'h720);
        chk("stall_done4", dn4_m, 32'h800);

        scen(16'h1235, 32'h3E0, 0, 16'h0, 0, 12);
        chk("dstall_rd", rd_m, 32'h1E);
        chk("dstall_we2", we2_m, 32'h78);
        chk("dstall_done2", dn2_m, 32'h80);
        chk("dstall_we4", we4_m, 32'h1E0);
        chk("dstall_done4", dn4_m, 32'h200);

        scen(16'h1235, 32'h0, 3, 16'hFFF8, 0, 12);
        chk("restart_err2", er2_m, 32'h8);
        chk("restart_err4", er4_m, 32'h8);
        chk("restart_rd", rd_m, 32'h1E);
        chk_addrs("restart_addr", 16'h1230);
        chk("restart_done2", dn2_m, 32'h80);

        scen(16'h1235, 32'h0, 0, 16'h0, 4, 12);
        chk("rst_rd", rd_m, 32'hE);
        chk("rst_we2", we2_m, 32'h8);
        chk("rst_busy2", bz2_m, 32'hE);
        chk("rst_done2", dn2_m, 32'h0);
        chk("rst_we1", we1_m, 32'hC);
        chk("rst_done1", dn1_m, 32'h0);
        chk("rst_we4", we4_m, 32'h0);
        chk("rst_done4", dn4_m, 32'h0);
        chk("rst_busy4", bz4_m, 32'hE);

        scen(16'h0000, 32'h0, 0, 16'h0, 0, 12);
        chk_addrs("post_rst_addr", 16'h0000);
        chk("post_rst_we2", we2_m, 32'h78);
        chk("post_rst_done2", dn2_m, 32'h80);

        scen(16'h1235, 32'h0, 7, 16'h0040, 0, 16);
        chk("b2b1_err1", er1_m, 32'h0);
        chk("b2b1_busy1", bz1_m, 32'h3F7E);
        chk("b2b1_done1", dn1_m, 32'h2040);
        chk("b2b1_err2", er2_m, 32'h80);
        chk("b2b1_busy2", bz2_m, 32'hFE);

        scen(16'h1235, 32'h0, 8, 16'h0040, 0, 18);
        chk("b2b2_err2", er2_m, 32'h0);
        chk("b2b2_busy2", bz2_m, 32'hFEFE);
        chk("b2b2_done2", dn2_m, 32'h8080);
        chk("b2b2_addr", addr_q.size() > 4 ? addr_q[4] : 16'h0, 16'h0040);
        chk("b2b2_err4", er4_m, 32'h100);

        scen(16'h1235, 32'h0, 10, 16'h0040, 0, 22);
        chk("b2b4_err4", er4_m, 32'h0);
        chk("b2b4_busy4", bz4_m, 32'hFFBFE);
        chk("b2b4_done4", dn4_m, 32'h80200);
        chk("b2b4_busy2", bz2_m, 32'h3F8FE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_fill_seq.md
# burst_fill_seq

Cache line-fill sequencer for the four-bank memory path. On a start request it issues four consecutive word reads for one 8-byte line (word offsets 0..3). It tracks the fixed-latency returns and presents each returned word to the cache data array with its 2-bit word offset. It sits between the cache controller FSM (start/busy/done) and the memory banks (read strobe/address/data).

## Interface
- LATENCY, 2, cycles from a read being issued to its data on mem_data_in; legal range 1..4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; forces IDLE and clears all counters and pipeline
- start  in  1  one-cycle request to fill the line containing base_addr
- base_addr  in  16  byte address; bits [2:0] ignored (line aligned internally)
- mem_stall  in  1  memory cannot accept a read this cycle
- mem_data_in  in  16  read data returning from memory
- mem_rd  out  1  read strobe
- mem_addr  out  16  read address; 16'h0000 whenever mem_rd=0
- fill_we  out  1  write strobe to the cache data array
- fill_word  out  2  word offset of the word on fill_data
- fill_data  out  16  equals mem_data_in (combinational pass-through)
- busy  out  1  high in ISSUE, DRAIN, DONE
- done  out  1  one-cycle pulse after the fourth fill write
- err  out  1  one-cycle pulse: start received while busy

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches base_addr[15:3] and clears issue_cnt, ret_cnt (2-bit each, plus terminal flags); goes to ISSUE.
- ISSUE: mem_rd = !mem_stall. mem_addr = {line[15:3], issue_cnt, 1'b0}.
  - Each issued read pushes {valid=1, offset=issue_cnt} into a LATENCY-deep return shift register, and issue_cnt increments.
  - Stalled cycles push valid=0.
  - After the read with issue_cnt=3 is issued, go to DRAIN. The count does not wrap into a fifth read.
- Return pipeline advances every cycle regardless of mem_stall. In-flight returns are never held.
  - Its output stage drives fill_we=valid and fill_word=offset.
  - ret_cnt increments on each fill_we.
- DRAIN: wait until the fill_we with ret_cnt=3 occurs, then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE. A new start is accepted the cycle after DONE.
- start while state != IDLE: ignored; err=1 that cycle; the current fill is unaffected.
- Word offsets are issued and returned strictly in order 0,1,2,3.
- Reset asserted mid-fill: all outputs go low immediately (asynchronous) and the state becomes IDLE. In-flight returns are discarded; no fill_we appears after reset deassertion.
- Reset values: mem_rd=0, mem_addr=0, fill_we=0, fill_word=0, busy=0, done=0, err=0.

## Timing
- start sampled at edge E0. ISSUE begins the cycle after E0 (cycle 1).
- With no stalls:
  - mem_rd is high in cycles 1–4.
  - fill_we is high in cycles 1+LATENCY .. 4+LATENCY.
  - done is high in cycle 5+LATENCY.
  - busy is high in cycles 1 .. 5+LATENCY.
- Each stalled issue cycle delays every later read, fill and done by one cycle.
- A stall in DRAIN has no effect.
- mem_rd and mem_addr are combinational from state, counter and mem_stall.
- fill_we, fill_word and done are registered outputs; fill_data is combinational.

## Test plan
- Basic fill, LATENCY=2, base_addr=16'h1235, no stall:
  - mem_rd cycles 1–4 with mem_addr 16'h1230, 1232, 1234, 1236.
  - fill_we cycles 3–6 with fill_word 0,1,2,3.
  - done only in cycle 7; busy cycles 1–7.
- Stall in cycles 2 and 3:
  - reads land in cycles 1, 4, 5, 6 with addresses in order.
  - fill_we in cycles 3, 6, 7, 8; done in cycle 9.
- Stall held throughout DRAIN: no change versus the unstalled fill timing.
- start re-asserted in cycle 3 with base_addr=16'hFFF8: err=1 in cycle 3 only; all addresses remain on the original line.
- rst asserted in cycle 4 for one cycle: all outputs 0 immediately; no fill_we or done afterwards. A following start at 16'h0000 completes a normal fill.
- LATENCY=1 and LATENCY=4 builds:
  - fill_we cycles 2–5 / 5–8.
  - done in cycle 6 / 9.
  - back-to-back start in the cycle after done is accepted with err=0.
